// File: rtl/branch_resolve_unit_if.sv
// Bundles the branch request inputs and the registered resolution outputs of
// branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int WIDTH     = 16,
  parameter int PC_WIDTH  = 16,
  parameter int OFF_WIDTH = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 stall;
  logic [2:0]           cond;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [PC_WIDTH-1:0]  pc_next;
  logic [OFF_WIDTH-1:0] offset;
  logic                 out_valid;
  logic                 taken;
  logic [PC_WIDTH-1:0]  target;
  logic                 flush;
  logic [CNT_WIDTH-1:0] taken_count;

  modport master (
    output in_valid, stall, cond, op_a, op_b, pc_next, offset,
    input  out_valid, taken, target, flush, taken_count
  );

  modport slave (
    input  in_valid, stall, cond, op_a, op_b, pc_next, offset,
    output out_valid, taken, target, flush, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates the condition, registers the decision and
// target, squashes younger slots after a taken branch, and counts taken branches.
module branch_resolve_unit #(
  parameter int WIDTH        = 16,
  parameter int PC_WIDTH     = 16,
  parameter int OFF_WIDTH    = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolve_unit_if.slave bus
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t               r_state, w_state_nxt;
  logic [FC_W-1:0]      r_flush_cnt, w_flush_cnt_nxt;
  logic                 r_out_valid, r_taken;
  logic [PC_WIDTH-1:0]  r_target;
  logic [CNT_WIDTH-1:0] r_count;

  logic [WIDTH:0]       w_diff;
  logic                 w_eq, w_lt_s, w_lt_u, w_cond_true, w_capture;
  logic [PC_WIDTH-1:0]  w_target;

  assign w_diff = {bus.op_a[WIDTH-1], bus.op_a} - {bus.op_b[WIDTH-1], bus.op_b};
  assign w_eq   = (w_diff == '0);
  assign w_lt_s = w_diff[WIDTH];
  // Top result bit is a_msb ^ b_msb ^ borrow-in, so the W-bit borrow falls out of the same subtractor.
  assign w_lt_u = w_diff[WIDTH] ^ bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];

  assign w_target = bus.pc_next + PC_WIDTH'(signed'(bus.offset));

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      3'b000:  w_cond_true = w_eq;
      3'b001:  w_cond_true = !w_eq;
      3'b010:  w_cond_true = w_lt_s;
      3'b011:  w_cond_true = !w_lt_s;
      3'b100:  w_cond_true = w_lt_u;
      3'b101:  w_cond_true = !w_lt_u;
      3'b110:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_capture       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && !bus.stall) begin
          w_capture = 1'b1;
          if (w_cond_true) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
          end
        end
      end
      default: begin
        if (!bus.stall) begin
          if (r_flush_cnt == FC_W'(1)) begin
            w_state_nxt     = S_IDLE;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_count     <= '0;
    end else if (!bus.stall) begin
      r_out_valid <= w_capture;
      if (w_capture) begin
        r_taken  <= w_cond_true;
        r_target <= w_cond_true ? w_target : bus.pc_next;
        if (w_cond_true && r_count != '1) r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.taken       = r_taken;
  assign bus.target      = r_target;
  assign bus.flush       = (r_state == S_FLUSH);
  assign bus.taken_count = r_count;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on each fresh out_valid.
module tb_branch_resolve_unit;
  localparam int W = 16, PW = 16, OW = 8, FC = 2, CW = 2;
  localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLT = 3'd2, BGE = 3'd3,
                         BLTU = 3'd4, BGEU = 3'd5, ALW = 3'd6, NEV = 3'd7;

  typedef struct {
    logic          taken;
    logic [PW-1:0] target;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WIDTH(W), .PC_WIDTH(PW), .OFF_WIDTH(OW), .CNT_WIDTH(CW)) bus ();
  branch_resolve_unit #(.WIDTH(W), .PC_WIDTH(PW), .OFF_WIDTH(OW), .FLUSH_CYCLES(FC),
                        .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0, pops = 0;
  logic [CW-1:0] m_cnt = '0;
  exp_t q[$];
  bit last_adv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [PW-1:0] pc, input logic [OW-1:0] off);
    bus.in_valid = v; bus.cond = c; bus.op_a = a; bus.op_b = b;
    bus.pc_next = pc; bus.offset = off;
  endtask

  task automatic push(input logic tk, input logic [PW-1:0] tgt);
    exp_t e;
    if (tk && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    e.taken = tk; e.target = tgt; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW-1:0] pc, input logic [OW-1:0] off,
                       input logic tk, input logic [PW-1:0] tgt);
    set_in(1'b1, c, a, b, pc, off);
    push(tk, tgt);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after a taken capture: flush for exactly FC cycles.
  task automatic flush_seq(input string nm);
    chk({nm, "_flush_c1"}, bus.flush, 1);
    tick();
    chk({nm, "_flush_c2"}, bus.flush, 1);
    chk({nm, "_ov_drop"}, bus.out_valid, 0);
    tick();
    chk({nm, "_flush_end"}, bus.flush, 0);
  endtask

  always @(posedge clk) last_adv = !bus.stall;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.out_valid === 1'b1 && last_adv) begin
      pops++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got taken=%0b target=%0h with empty queue",
                 bus.taken, bus.target);
      end else begin
        e = q.pop_front();
        chk("result{taken,target,count}", {bus.taken, bus.target, bus.taken_count},
            {e.taken, e.target, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1;
    bus.stall = 1'b0;
    set_in(1'b0, BEQ, '0, '0, '0, '0);
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_taken", bus.taken, 0);
    chk("rst_target", bus.target, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_count", bus.taken_count, 0);
    rst = 1'b0;
    tick();

    issue(BNE, 16'h1234, 16'h1234, 16'h0010, 8'h05, 1'b0, 16'h0010);
    chk("bne_flush", bus.flush, 0);
    issue(BLT, 16'hFFFF, 16'h0001, 16'h0020, 8'hFC, 1'b1, 16'h001C);
    flush_seq("blt");
    issue(BLTU, 16'hFFFF, 16'h0001, 16'h0020, 8'hFC, 1'b0, 16'h0020);
    chk("bltu_flush", bus.flush, 0);
    issue(BLT, 16'h8000, 16'h7FFF, 16'h0030, 8'h10, 1'b1, 16'h0040);
    flush_seq("blt_ovf");
    issue(BGE, 16'h8000, 16'h7FFF, 16'h0030, 8'h10, 1'b0, 16'h0030);
    chk("bge_flush", bus.flush, 0);
    issue(BGEU, 16'h0001, 16'hFFFF, 16'h0050, 8'h01, 1'b0, 16'h0050);
    tick();

    // Taken BEQ with in_valid held for three more cycles.
    n0 = pops;
    set_in(1'b1, BEQ, 16'h5555, 16'h5555, 16'h0100, 8'h02);
    push(1'b1, 16'h0102);
    tick();
    set_in(1'b1, BNE, 16'h0007, 16'h0007, 16'h0200, 8'h01);
    chk("beq_hold_flush1", bus.flush, 1);
    tick();
    chk("beq_hold_flush2", bus.flush, 1);
    chk("beq_hold_ignored", bus.out_valid, 0);
    tick();
    chk("beq_hold_idle", bus.flush, 0);
    push(1'b0, 16'h0200);
    tick();
    bus.in_valid = 1'b0;
    chk("beq_third_flush", bus.flush, 0);
    tick();
    chk("beq_pulses", pops - n0, 2);

    // Stall during the first flush cycle.
    issue(ALW, 16'h0000, 16'h0000, 16'h0300, 8'h7F, 1'b1, 16'h037F);
    chk("stall_flush_c1", bus.flush, 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flush_held", bus.flush, 1);
      chk("stall_ov_held", bus.out_valid, 1);
      chk("stall_out_held", {bus.taken, bus.target}, {1'b1, 16'h037F});
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_flush_last", bus.flush, 1);
    chk("stall_ov_drop", bus.out_valid, 0);
    tick();
    chk("stall_flush_end", bus.flush, 0);

    // Reset in the middle of a flush.
    issue(ALW, 16'h0000, 16'h0000, 16'h0400, 8'h00, 1'b1, 16'h0400);
    tick();
    chk("midrst_flush_before", bus.flush, 1);
    rst = 1'b1;
    #1;
    chk("midrst_flush", bus.flush, 0);
    chk("midrst_count", bus.taken_count, 0);
    chk("midrst_taken", bus.taken, 0);
    chk("midrst_target", bus.target, 0);
    m_cnt = '0;
    tick();
    rst = 1'b0;
    tick();

    // Counter saturation plus target wrap.
    issue(ALW, 16'h1111, 16'h2222, 16'hFFFE, 8'h03, 1'b1, 16'h0001);
    flush_seq("cnt1");
    issue(ALW, 16'h1111, 16'h2222, 16'h0010, 8'h01, 1'b1, 16'h0011);
    flush_seq("cnt2");
    issue(ALW, 16'h1111, 16'h2222, 16'h0020, 8'hFF, 1'b1, 16'h001F);
    flush_seq("cnt3");
    issue(ALW, 16'h1111, 16'h2222, 16'h0030, 8'h80, 1'b1, 16'hFFB0);
    flush_seq("cnt4");
    issue(ALW, 16'h1111, 16'h2222, 16'h0040, 8'h00, 1'b1, 16'h0040);
    flush_seq("cnt5");
    chk("cnt_saturated", bus.taken_count, 3);

    issue(NEV, 16'h0001, 16'h0001, 16'h0500, 8'h05, 1'b0, 16'h0500);
    chk("never_flush", bus.flush, 0);
    tick(); tick();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
